// File: rtl/bcd_countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer_pkg
// Brief    : Shared types, constants and helpers for the BCD countdown timer
// Revision : 1.0 - initial release
// ============================================================================
package bcd_countdown_timer_pkg;

    // Timer control state: stopped or counting down
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Largest legal BCD digit
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Saturate an arbitrary nibble to a legal BCD digit
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_countdown_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer_if
// Brief    : Control/status bundle between a controller and the BCD timer
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_countdown_timer_if;
    logic       load;
    logic [3:0] d_tens;
    logic [3:0] d_ones;
    logic       en;
    logic [3:0] q_tens;
    logic [3:0] q_ones;
    logic       zero;
    logic       done;
    logic       busy;

    // Controller side: drives load/data/enable, observes the count
    modport master (
        output load, d_tens, d_ones, en,
        input  q_tens, q_ones, zero, done, busy
    );

    // Timer side
    modport slave (
        input  load, d_tens, d_ones, en,
        output q_tens, q_ones, zero, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_digit
// Brief    : One BCD digit that loads or decrements, 0 wraps to 9 with borrow
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_digit
    import bcd_countdown_timer_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       dec_in,
    input  wire logic       load,
    input  wire logic [3:0] d,
    output logic      [3:0] q,
    output logic            borrow_out
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Load wins over decrement; decrementing 0 wraps to 9
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (dec_in) begin
            q_d = (q_q == 4'd0) ? BCD_MAX : (q_q - 4'd1);
        end
    end

    // Digit register, updated on the falling edge
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign borrow_out = dec_in & (q_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer
// Brief    : Two-digit BCD down counter with terminal-count pulse and reload
// Revision : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  wire logic           clk,
    input  wire logic           reset,
    bcd_countdown_timer_if.slave bus
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] reload_tens_q;
    logic [3:0] reload_tens_d;
    logic [3:0] reload_ones_q;
    logic [3:0] reload_ones_d;
    logic       done_q;
    logic       done_d;

    logic [3:0] w_ld_tens;
    logic [3:0] w_ld_ones;
    logic [3:0] w_q_tens;
    logic [3:0] w_q_ones;
    logic       w_step;
    logic       w_terminal;
    logic       w_reload_now;
    logic       w_digit_load;
    logic [3:0] w_digit_tens_d;
    logic [3:0] w_digit_ones_d;
    logic       w_ones_borrow;
    logic       w_tens_borrow;

    assign w_ld_tens = bcd_clamp(bus.d_tens);
    assign w_ld_ones = bcd_clamp(bus.d_ones);

    // A count step happens only in RUN with enable and no competing load
    assign w_step       = bus.en & (state_q == RUN) & ~bus.load;
    assign w_terminal   = w_step & (w_q_tens == 4'd0) & (w_q_ones == 4'd1);
    // With auto-reload the terminal edge reloads the digits instead of reaching 00
    assign w_reload_now = w_terminal & AUTO_RELOAD;
    assign w_digit_load = bus.load | w_reload_now;
    assign w_digit_tens_d = bus.load ? w_ld_tens : reload_tens_q;
    assign w_digit_ones_d = bus.load ? w_ld_ones : reload_ones_q;

    bcd_down_digit u_ones (
        .clk        (clk),
        .reset      (reset),
        .dec_in     (w_step),
        .load       (w_digit_load),
        .d          (w_digit_ones_d),
        .q          (w_q_ones),
        .borrow_out (w_ones_borrow)
    );

    bcd_down_digit u_tens (
        .clk        (clk),
        .reset      (reset),
        .dec_in     (w_ones_borrow),
        .load       (w_digit_load),
        .d          (w_digit_tens_d),
        .q          (w_q_tens),
        .borrow_out (w_tens_borrow)
    );

    // State register
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: load decides RUN/IDLE from its value, terminal count stops
    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = ({w_ld_tens, w_ld_ones} != 8'h00) ? RUN : IDLE;
        end else if (w_terminal && !AUTO_RELOAD) begin
            state_d = IDLE;
        end else if (w_tens_borrow) begin
            // Stepping below 00 would wrap to 99; stop rather than wrap
            state_d = IDLE;
        end
    end

    // Outputs decoded from registers only
    always_comb begin
        bus.busy = (state_q == RUN);
        bus.zero = (w_q_tens == 4'd0) && (w_q_ones == 4'd0);
    end

    assign bus.q_tens = w_q_tens;
    assign bus.q_ones = w_q_ones;
    assign bus.done   = done_q;

    // Reload value follows every load
    always_comb begin
        reload_tens_d = reload_tens_q;
        reload_ones_d = reload_ones_q;
        done_d        = w_terminal;
        if (bus.load) begin
            reload_tens_d = w_ld_tens;
            reload_ones_d = w_ld_ones;
        end
    end

    // Reload register and one-period done pulse
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            reload_tens_q <= 4'd0;
            reload_ones_q <= 4'd0;
            done_q        <= 1'b0;
        end else begin
            reload_tens_q <= reload_tens_d;
            reload_ones_q <= reload_ones_d;
            done_q        <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_countdown_timer
// Brief    : Directed + random bench for both AUTO_RELOAD settings
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] d_tens;
    logic [3:0] d_ones;
    logic       en;

    int total;
    int bad;

    // Reference model: count as a plain integer 0..99 per instance
    int m_cnt  [2];
    int m_rel  [2];
    bit m_run  [2];
    bit m_done [2];

    bcd_countdown_timer_if if0 ();
    bcd_countdown_timer_if if1 ();

    assign if0.load   = load;
    assign if0.d_tens = d_tens;
    assign if0.d_ones = d_ones;
    assign if0.en     = en;
    assign if1.load   = load;
    assign if1.d_tens = d_tens;
    assign if1.d_ones = d_ones;
    assign if1.en     = en;

    bcd_countdown_timer #(.AUTO_RELOAD(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    bcd_countdown_timer #(.AUTO_RELOAD(1'b1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_rel[k]  = 0;
            m_run[k]  = 1'b0;
            m_done[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit ld, input int dt, input int dn, input bit e);
        int v;
        v = ((dt > 9) ? 9 : dt) * 10 + ((dn > 9) ? 9 : dn);
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (ld) begin
                m_cnt[k] = v;
                m_rel[k] = v;
                m_run[k] = (v != 0);
            end else if (m_run[k] && e) begin
                if (m_cnt[k] == 1) begin
                    m_done[k] = 1'b1;
                    if (k == 1) begin
                        m_cnt[k] = m_rel[k];
                    end else begin
                        m_cnt[k] = 0;
                        m_run[k] = 1'b0;
                    end
                end else begin
                    m_cnt[k] = m_cnt[k] - 1;
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input logic [3:0] qt, input logic [3:0] qo,
                             input logic z, input logic dn, input logic b);
        check($sformatf("q_tens[ar%0d]", k), {28'd0, qt}, m_cnt[k] / 10);
        check($sformatf("q_ones[ar%0d]", k), {28'd0, qo}, m_cnt[k] % 10);
        check($sformatf("zero[ar%0d]", k),   {31'd0, z},  (m_cnt[k] == 0) ? 1 : 0);
        check($sformatf("done[ar%0d]", k),   {31'd0, dn}, m_done[k] ? 1 : 0);
        check($sformatf("busy[ar%0d]", k),   {31'd0, b},  m_run[k] ? 1 : 0);
    endtask

    task automatic check_all();
        check_dut(0, if0.q_tens, if0.q_ones, if0.zero, if0.done, if0.busy);
        check_dut(1, if1.q_tens, if1.q_ones, if1.zero, if1.done, if1.busy);
    endtask

    // One falling-edge cycle; reset takes effect immediately, checked before the edge too
    task automatic cyc(input bit ld, input int dt, input int dn, input bit e, input bit r);
        load   = ld;
        d_tens = dt[3:0];
        d_ones = dn[3:0];
        en     = e;
        reset  = r;
        if (r) begin
            #1;
            model_reset();
            check_all();
        end
        @(negedge clk);
        #1;
        if (r) model_reset();
        else   model_edge(ld, dt, dn, e);
        check_all();
    endtask

    initial begin
        int rdt;
        int rdn;
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        load   = 1'b0;
        en     = 1'b0;
        d_tens = 4'd0;
        d_ones = 4'd0;
        model_reset();
        #1;
        check_all();

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);

        // Full countdown from 25 and beyond
        cyc(1, 2, 5, 1, 0);
        repeat (28) cyc(0, 0, 0, 1, 0);

        // Borrow, clamp, hold
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 12, 15, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        // Load priority over enable
        cyc(1, 3, 4, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 5, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Short count exercising terminal count and reload
        cyc(1, 0, 3, 0, 0);
        repeat (8) cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);

        // Reset in the middle of a count at 47
        cyc(1, 5, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // Random traffic, biased toward small loads so terminal count is frequent
        for (int i = 0; i < 600; i++) begin
            rdt = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1));
            rdn = int'($urandom_range(0, 15));
            cyc(($urandom_range(0, 11) == 0), rdt, rdn,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Two-digit BCD (00–99) down-counting timer: the count-down counterpart to the team's four-bit decade up counter. A value is loaded, then decremented once per enabled clock edge with decimal borrow between digits. The block flags terminal count and optionally reloads itself. It drives seven-segment/timer logic in the same lab designs as the up counter.

## Interface
- AUTO_RELOAD, 0, when 1 the count reloads the last loaded value instead of stopping at 00

- clk  input  1  clock; all state updates on the falling edge, matching the team's JK-flop counters
- reset  input  1  asynchronous, active-high; clears all state immediately
- load  input  1  load d_tens/d_ones on this edge
- d_tens  input  4  BCD tens digit to load
- d_ones  input  4  BCD ones digit to load
- en  input  1  count enable; decrement when 1 in RUN
- q_tens  output  4  current tens digit, BCD
- q_ones  output  4  current ones digit, BCD
- zero  output  1  1 when q_tens==0 and q_ones==0
- done  output  1  one-cycle pulse on terminal count
- busy  output  1  1 while state is RUN

## Operation
- State machine with 2 states:
  - IDLE: counter is stopped; en is ignored.
  - RUN: counter decrements on each enabled edge.
- Load handling:
  - load has priority over en in either state; the decrement is suppressed on that edge.
  - On load, each digit > 9 is clamped to 9 before storage.
  - The clamped value is written to both the count registers and the reload register.
  - Next state is RUN if the loaded value is nonzero, otherwise IDLE. Loading 00 never produces done.
- Decrement in RUN (en=1, load=0):
  - If q_ones != 0, q_ones decrements by 1.
  - If q_ones == 0, q_ones becomes 9 and q_tens decrements by 1 (borrow).
  - q_tens never underflows, because RUN always exits at 00.
- Terminal count (RUN, en=1, count == 01):
  - AUTO_RELOAD=0: count becomes 00, state becomes IDLE, done=1.
  - AUTO_RELOAD=1: count becomes the reload register value, state stays RUN, done=1.
- Hold: en=0 in RUN holds the count, done=0.
- There is no wrap from 00 to 99; en in IDLE has no effect.
- Reset:
  - Forces q_tens=0, q_ones=0, reload register 00, state IDLE, done=0, busy=0.
  - zero=1 during and after reset.
  - Reset asserted mid-count aborts without a done pulse.

## Timing
- All outputs are registered (zero is decoded from registers only) and change only after a falling clk edge or on reset assertion.
- Load-to-output latency: 1 falling edge. busy goes high on the same edge.
- Decrement latency: 1 falling edge per enabled step. A loaded value N reaches terminal count on the N-th enabled edge after load.
- done is high for exactly one clock period, from the terminal edge to the next falling edge.
- Back-to-back loads: each load takes effect on its own edge; the latest load wins.
- Reset release: the first possible state change is the first falling edge with reset=0.

## Structure
- Shared package:
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - BCD_MAX constant = 4'd9.
  - BCD clamp function (digit > 9 returns 9).
- Sub-module bcd_down_digit, instantiated twice (ones, then tens):
  - Inputs: dec_in, load, d.
  - Outputs: q, borrow_out, where borrow_out = dec_in & (q==0).
  - Ones digit dec_in = en & RUN & ~load; tens digit dec_in = ones borrow_out.
- Top level owns the FSM, the reload register, the terminal-count detect (count==01 & step) and the done register.

## Test plan
- Reset: assert reset mid-cycle with count 47 -> immediately q=00, zero=1, busy=0, done=0. No done pulse at release.
- Full countdown: load 25, hold en=1 -> q steps 24…01, reaches 00 on the 25th enabled edge with done=1 for one cycle. Then IDLE, busy=0, and further en leaves 00.
- Borrow/clamp/hold:
  - load 10, one enabled edge -> 09.
  - load tens=12, ones=15 -> q=99.
  - en=0 for 3 edges -> q unchanged.
- Priority: load 50 with en=1 on the same edge while counting at 33 -> q=50 (not 49), next enabled edge -> 49. Load 00 -> IDLE, done stays 0.
- Auto reload: AUTO_RELOAD=1, load 03, en=1 -> 02, 01, 03 (done=1 on that edge), 02, … and busy remains 1 throughout.
